// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// IF_MISALIGN_CHK_EN (see fetch_stage) adds the HALT path.
package fetch_stage_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = 32'd4;
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = 32'h0000_0003;

    typedef logic [2:0] fetch_state_e;

    localparam fetch_state_e IDLE    = 3'd0;
    localparam fetch_state_e REQ     = 3'd1;
    localparam fetch_state_e WAIT    = 3'd2;
    localparam fetch_state_e FULL    = 3'd3;
    localparam fetch_state_e DISCARD = 3'd4;
    localparam fetch_state_e HALT    = 3'd5;

    function automatic logic [DATA_WIDTH-1:0] word_align(
        input logic [DATA_WIDTH-1:0] a
    );
        return a & ~ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_program_counter.sv
// Fetch PC register: reset value, +4 step, redirect load.
// Redirect targets are always word aligned before loading.
module program_counter
    import fetch_stage_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    input  logic                  incr_i,
    output logic [DATA_WIDTH-1:0] pc_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(target_i);
        end else if (incr_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem port, skid, IF/ID reg.
// Define IF_MISALIGN_CHK_EN to trap misaligned redirects (IF_misaligned_o, HALT).
module fetch_stage #(
    parameter logic [fetch_stage_pkg::DATA_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [fetch_stage_pkg::DATA_WIDTH-1:0] NOP_INSTR =
        fetch_stage_pkg::NOP_INSTR
) (
    input  logic                                  clk,
    input  logic                                  rst,
    output logic                                  imem_req_o,
    output logic [fetch_stage_pkg::DATA_WIDTH-1:0] imem_addr_o,
    input  logic                                  imem_gnt_i,
    input  logic                                  imem_rvalid_i,
    input  logic [fetch_stage_pkg::DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                                  ID_stall_i,
    input  logic                                  ID_PCSrc_i,
    input  logic [fetch_stage_pkg::DATA_WIDTH-1:0] ID_branch_target_addr_i,
`ifdef IF_MISALIGN_CHK_EN
    output logic                                  IF_misaligned_o,
`endif
    output logic                                  IF_valid_o,
    output logic [fetch_stage_pkg::DATA_WIDTH-1:0] IF_instruction_o,
    output logic [fetch_stage_pkg::DATA_WIDTH-1:0] IF_pc_o
);

    import fetch_stage_pkg::*;

    fetch_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] opc_q, opc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                  valid_q, valid_d;
    logic                  pend_q, pend_d;

    logic req;
    logic pc_load;
    logic pc_incr;
    logic take_out;
    logic take_skid;
    logic skid_load;
    logic out_free;
    logic misal;

    assign out_free = !valid_q || !ID_stall_i;

`ifdef IF_MISALIGN_CHK_EN
    logic mis_q, mis_d;

    assign misal = |ID_branch_target_addr_i[1:0];
    assign mis_d = ID_PCSrc_i ? misal : mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign IF_misaligned_o = mis_q;
`else
    assign misal = 1'b0;
`endif

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_i   (pc_load),
        .target_i (ID_branch_target_addr_i),
        .incr_i   (pc_incr),
        .pc_o     (pc)
    );

    // Redirect overrides every other transition out of the current state.
    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        pc_load   = 1'b0;
        pc_incr   = 1'b0;
        take_out  = 1'b0;
        take_skid = 1'b0;
        skid_load = 1'b0;
        if (ID_PCSrc_i) begin
            pc_load = 1'b1;
            unique case (state_q)
                REQ: begin
                    req     = 1'b1;
                    state_d = imem_gnt_i ? DISCARD : REQ;
                end
                WAIT:    state_d = imem_rvalid_i ? REQ : DISCARD;
                DISCARD: state_d = imem_rvalid_i ? REQ : DISCARD;
                HALT: begin
                    state_d = (pend_q && !imem_rvalid_i) ? DISCARD : REQ;
                end
                default: state_d = REQ;
            endcase
            if (misal) begin
                state_d = HALT;
            end
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    req = 1'b1;
                    if (imem_gnt_i) begin
                        pc_incr = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i && out_free) begin
                        take_out = 1'b1;
                        req      = 1'b1;
                        if (imem_gnt_i) begin
                            pc_incr = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
                    end else if (imem_rvalid_i) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (!ID_stall_i) begin
                        take_skid = 1'b1;
                        state_d   = REQ;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid_i) begin
                        state_d = REQ;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Track an in-flight response so leaving HALT never loses a stale word.
    always_comb begin
        pend_d = pend_q;
        if (req && imem_gnt_i) begin
            pend_d = 1'b1;
        end else if (imem_rvalid_i) begin
            pend_d = 1'b0;
        end
    end

    assign fetch_pc_d   = (req && imem_gnt_i) ? pc : fetch_pc_q;
    assign skid_instr_d = skid_load ? imem_rdata_i : skid_instr_q;
    assign skid_pc_d    = skid_load ? fetch_pc_q : skid_pc_q;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        if (ID_PCSrc_i) begin
            valid_d = 1'b0;
        end else if (take_out) begin
            valid_d = 1'b1;
            instr_d = imem_rdata_i;
            opc_d   = fetch_pc_q;
        end else if (take_skid) begin
            valid_d = 1'b1;
            instr_d = skid_instr_q;
            opc_d   = skid_pc_q;
        end else if (!ID_stall_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            fetch_pc_q   <= '0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            opc_q        <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            fetch_pc_q   <= fetch_pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req_o       = req;
    assign imem_addr_o      = pc;
    assign IF_valid_o       = valid_q;
    assign IF_instruction_o = valid_q ? instr_q : NOP_INSTR;
    assign IF_pc_o          = opc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic
// scored against a program-order model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] tgt = '0;
    logic        valid;
    logic [31:0] ins;
    logic [31:0] opc;
`ifdef IF_MISALIGN_CHK_EN
    logic        mis;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .imem_req_o              (req),
        .imem_addr_o             (addr),
        .imem_gnt_i              (gnt),
        .imem_rvalid_i           (rvalid),
        .imem_rdata_i            (rdata),
        .ID_stall_i              (stall),
        .ID_PCSrc_i              (pcsrc),
        .ID_branch_target_addr_i (tgt),
`ifdef IF_MISALIGN_CHK_EN
        .IF_misaligned_o         (mis),
`endif
        .IF_valid_o              (valid),
        .IF_instruction_o        (ins),
        .IF_pc_o                 (opc)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1A2B;
    endfunction

    // Memory: random grant, response 1+lat cycles after grant.
    int          gnt_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_cnt = 0;
    logic        m_acc;
    logic [31:0] m_acc_a;
    logic        m_took;

    initial begin
        forever begin
            @(negedge clk);
            m_acc   = req & gnt;
            m_acc_a = addr;
            m_took  = rvalid;
            @(posedge clk);
            #1;
            if (rst) begin
                m_pend = 1'b0;
                gnt    = 1'b0;
                rvalid = 1'b0;
                rdata  = $urandom;
            end else begin
                if (m_took) m_pend = 1'b0;
                if (m_acc) begin
                    m_pend = 1'b1;
                    m_addr = m_acc_a;
                    m_cnt  = $urandom_range(lat_max, lat_min);
                end else if (m_pend && m_cnt > 0) begin
                    m_cnt--;
                end
                rvalid = m_pend && (m_cnt == 0);
                rdata  = rvalid ? memfn(m_addr) : $urandom;
                gnt    = ($urandom_range(99, 0) < gnt_pct);
            end
        end
    end

    // Model: the stream handed to decode is program order from the last
    // redirect (or reset), each word carrying memory's contents at its PC.
    logic [31:0] e_pc = RESET_PC;
    logic        e_halt = 1'b0;
    logic        p_redir = 1'b0;
    logic        p_hold = 1'b0;
    logic        p_wait = 1'b0;
    logic [31:0] p_pc, p_ins, p_addr;
    int          n_acc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                e_pc    = RESET_PC;
                e_halt  = 1'b0;
                p_redir = 1'b0;
                p_hold  = 1'b0;
                p_wait  = 1'b0;
            end else begin
                if (p_redir) begin
                    chk("valid after redirect", valid, 0);
                end else if (p_hold) begin
                    chk("stall hold valid", valid, 1);
                    chk("stall hold pc", opc, p_pc);
                    chk("stall hold instr", ins, p_ins);
                end
                if (valid) begin
                    chk("pc order", opc, e_pc);
                    chk("instr data", ins, memfn(opc));
                end else begin
                    chk("nop when invalid", ins, NOP);
                end
                if (p_wait) begin
                    chk("req held", req, 1);
                    chk("addr held", addr, p_addr);
                end
                if (req) chk("addr aligned", addr[1:0], 0);
                if (req && gnt) chk("single outstanding", m_pend & ~rvalid, 0);
`ifdef IF_MISALIGN_CHK_EN
                chk("misaligned flag", mis, e_halt);
                if (e_halt) begin
                    chk("halt no valid", valid, 0);
                    chk("halt no req", req, 0);
                end
`endif
                if (valid && !stall && !pcsrc) n_acc++;
                p_redir = pcsrc;
                p_hold  = valid && stall && !pcsrc;
                p_pc    = opc;
                p_ins   = ins;
                p_wait  = req && !gnt && !pcsrc;
                p_addr  = addr;
                if (pcsrc) begin
                    e_pc = tgt & ~32'h3;
`ifdef IF_MISALIGN_CHK_EN
                    e_halt = (tgt[1:0] != 2'b00);
`endif
                end else if (valid && !stall) begin
                    e_pc = e_pc + 32'd4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals();
        chk("rst req", req, 0);
        chk("rst valid", valid, 0);
        chk("rst instr", ins, NOP);
        chk("rst pc", opc, 0);
        chk("rst addr", addr, RESET_PC);
`ifdef IF_MISALIGN_CHK_EN
        chk("rst misaligned", mis, 0);
`endif
    endtask

    task automatic do_reset();
        tick();
        rst   = 1'b1;
        stall = 1'b0;
        pcsrc = 1'b0;
        #1;
        check_reset_vals();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_new(input string name, input logic [31:0] excl);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (valid && opc != excl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_grant(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (req && gnt) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: zero-wait memory streams one word per cycle
        gnt_pct = 100;
        lat_min = 0;
        lat_max = 0;
        do_reset();
        wait_valid("t1 first valid timeout");
        for (int i = 0; i < 4; i++) begin
            chk("t1 valid", valid, 1);
            chk("t1 pc", opc, 32'(i * 4));
            tick();
        end

        // 2: stall while PC 8 is on the output
        do_reset();
        wait_new("t2 reach pc 8 timeout", 32'h0);
        while (valid && opc != 32'h8) tick();
        chk("t2 pc 8", opc, 32'h8);
        stall = 1'b1;
        tick();
        chk("t2 hold pc c1", opc, 32'h8);
        chk("t2 no req in full", req, 0);
        tick();
        chk("t2 hold pc c2", opc, 32'h8);
        tick();
        chk("t2 hold pc c3", opc, 32'h8);
        chk("t2 hold valid", valid, 1);
        stall = 1'b0;
        wait_new("t2 skid timeout", 32'h8);
        chk("t2 skid pc", opc, 32'hC);
        tick();
        wait_new("t2 next timeout", 32'hC);
        chk("t2 next pc", opc, 32'h10);

        // 3: redirect while waiting; stale word arrives later
        lat_min = 2;
        lat_max = 2;
        do_reset();
        wait_grant("t3 grant timeout");
        tick();
        pcsrc = 1'b1;
        tgt   = 32'h100;
        tick();
        pcsrc = 1'b0;
        chk("t3 valid low", valid, 0);
        wait_valid("t3 valid timeout");
        chk("t3 pc", opc, 32'h100);
        chk("t3 instr", ins, memfn(32'h100));

        // 4: redirect and stall together
        lat_min = 0;
        lat_max = 0;
        do_reset();
        wait_valid("t4 valid timeout");
        stall = 1'b1;
        pcsrc = 1'b1;
        tgt   = 32'h40;
        tick();
        stall = 1'b0;
        pcsrc = 1'b0;
        chk("t4 valid low", valid, 0);
        wait_valid("t4 target timeout");
        chk("t4 pc", opc, 32'h40);

        // PC wraps modulo 2^32
        pcsrc = 1'b1;
        tgt   = 32'hFFFF_FFF8;
        tick();
        pcsrc = 1'b0;
        wait_valid("wrap timeout");
        chk("wrap pc0", opc, 32'hFFFF_FFF8);
        tick();
        chk("wrap pc1", opc, 32'hFFFF_FFFC);
        tick();
        chk("wrap valid", valid, 1);
        chk("wrap pc2", opc, 32'h0);

        // 5: grant withheld, then reset mid-wait
        gnt_pct = 0;
        do_reset();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5 req", req, 1);
            chk("t5 addr", addr, RESET_PC);
            tick();
        end
        gnt_pct = 100;
        lat_min = 3;
        lat_max = 3;
        wait_grant("t5 grant timeout");
        tick();
        rst = 1'b1;
        #1;
        check_reset_vals();
        tick();
        tick();
        rst = 1'b0;

        // 6: misaligned redirect
        lat_min = 0;
        lat_max = 0;
        do_reset();
        wait_valid("t6 valid timeout");
        pcsrc = 1'b1;
        tgt   = 32'h102;
        tick();
        pcsrc = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t6 misaligned", mis, 1);
            chk("t6 halt req", req, 0);
            chk("t6 halt valid", valid, 0);
            tick();
        end
        pcsrc = 1'b1;
        tgt   = 32'h200;
        tick();
        pcsrc = 1'b0;
        chk("t6 cleared", mis, 0);
        wait_valid("t6 resume timeout");
        chk("t6 resume pc", opc, 32'h200);
`else
        wait_valid("t6 valid timeout");
        chk("t6 aligned pc", opc, 32'h100);
        chk("t6 aligned instr", ins, memfn(32'h100));
`endif

        // Random traffic
        gnt_pct = 75;
        lat_min = 0;
        lat_max = 3;
        do_reset();
        begin
            int acc0;
            int r;
            acc0 = n_acc;
            for (int c = 0; c < 3000; c++) begin
                if (c == 1500) begin
                    do_reset();
                    gnt_pct = 50;
                end
                stall = ($urandom_range(99, 0) < 25);
                pcsrc = ($urandom_range(99, 0) < 3);
                r = $urandom_range(7, 0);
                if (r == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(3, 0) * 4);
                else if (r == 1) tgt = $urandom;
                else tgt = 32'($urandom_range(1023, 0) * 4);
                tick();
            end
            stall = 1'b0;
            pcsrc = 1'b0;
            chk("random progress", (n_acc - acc0) > 200, 1);
        end
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
